// File: rtl/seq_shifter.sv
// seq_shifter
//   Multi-cycle 32-bit shift unit for the ALU shift instructions (SLL, SRL, SRA).
//   Each SHIFT cycle applies one stage: a coarse step of COARSE_STEP bits while
//   the remaining count allows it, otherwise a 1-bit fine step.
//
//   Optional feature macro: SHIFT_ROTATE_EN
//     defined     : op 11 = ROR (bits leaving bit 0 re-enter at bit 31)
//     not defined : op 11 behaves exactly as SRL, no rotate logic
//
// Ports
//   clk      in   1   clock, rising edge
//   reset_n  in   1   synchronous active-low reset
//   start    in   1   request, accepted in IDLE or DONE
//   op       in   2   00 SLL, 01 SRL, 10 SRA, 11 ROR/SRL
//   shamt    in   5   shift amount 0..31
//   data_in  in  32   operand
//   busy     out  1   high while shifting
//   done     out  1   one-cycle pulse, result valid
//   result   out 32   shifted value, held until next accepted start
//
// Parameter
//   COARSE_STEP  bits per coarse step, power of two in 2..16 (default 8)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// SHIFT | one shift stage per edge until the remaining count reaches 0
// DONE  | result valid for one cycle; a new start may be accepted here

module seq_shifter #(
   parameter int COARSE_STEP = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [4:0]  shamt,
   input  logic [31:0] data_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [4:0] STEP_C = 5'(COARSE_STEP);

   state_t      state;
   logic [31:0] work;
   logic [4:0]  cnt;
   logic [1:0]  op_q;
   logic        sign_q;

   logic                   coarse;
   logic [4:0]             step;
   logic                   fill;
   logic [COARSE_STEP-1:0] fill_c;
   logic                   fill_f;
   logic [31:0]            next_work;

   always_comb begin
      coarse = (cnt >= STEP_C);
      step   = coarse ? STEP_C : 5'd1;
      // only SRA fills from the left with something other than zero
      fill   = (op_q == 2'b10) & sign_q;
`ifdef SHIFT_ROTATE_EN
      fill_c = (op_q == 2'b11) ? work[COARSE_STEP-1:0] : {COARSE_STEP{fill}};
      fill_f = (op_q == 2'b11) ? work[0] : fill;
`else
      fill_c = {COARSE_STEP{fill}};
      fill_f = fill;
`endif
      if (op_q == 2'b00) begin
         next_work = coarse ? (work << COARSE_STEP) : {work[30:0], 1'b0};
      end else begin
         next_work = coarse ? {fill_c, work[31:COARSE_STEP]} : {fill_f, work[31:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= IDLE;
         work   <= 32'h0;
         cnt    <= 5'd0;
         op_q   <= 2'b00;
         sign_q <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  work   <= data_in;
                  cnt    <= shamt;
                  op_q   <= op;
                  sign_q <= data_in[31];
                  if (shamt == 5'd0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= SHIFT;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
            SHIFT: begin
               work <= next_work;
               cnt  <= cnt - step;
               if (cnt == step) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign result = work;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: stimulus pushes expected result and done
// cycle, a monitor pops and compares on every done pulse.

module tb_seq_shifter;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic        start   = 1'b0;
   logic [1:0]  op      = 2'b00;
   logic [4:0]  shamt   = 5'd0;
   logic [31:0] data_in = 32'h0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   seq_shifter #(.COARSE_STEP(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .shamt   (shamt),
      .data_in (data_in),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          at;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called just after a negedge; start is high for the current cycle.
   task automatic go(input string name, input logic [1:0] o, input logic [4:0] s,
                     input logic [31:0] d, input logic [31:0] exp_res, input int lat,
                     input bit push);
      exp_t e;
      start   = 1'b1;
      op      = o;
      shamt   = s;
      data_in = d;
      e.res   = exp_res;
      e.at    = cyc + lat;
      e.name  = name;
      if (push) sbq.push_back(e);
      @(negedge clk);
      start   = 1'b0;
      op      = 2'($urandom);
      shamt   = 5'($urandom);
      data_in = $urandom;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (done) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got result %h at cycle %0d, required no done", result, cyc);
         end else begin
            e = sbq.pop_front();
            checks++;
            if (result !== e.res) begin
               errors++;
               $display("FAIL %s_result: got %h required %h", e.name, result, e.res);
            end
            checks++;
            if (cyc != e.at) begin
               errors++;
               $display("FAIL %s_latency: done at cycle %0d required %0d", e.name, cyc, e.at);
            end
         end
      end
   end

   initial begin
      int a;
      repeat (3) @(negedge clk);
      check("reset_busy",   {31'h0, busy},   32'h0);
      check("reset_done",   {31'h0, done},   32'h0);
      check("reset_result", result,          32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // zero shift: done next cycle, busy never high
      go("sll0", 2'b00, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1'b1);
      check("sll0_busy", {31'h0, busy}, 32'h0);
      repeat (2) @(negedge clk);

      // one coarse step
      go("sll8", 2'b00, 5'd8, 32'h00000001, 32'h00000100, 2, 1'b1);
      check("sll8_busy", {31'h0, busy}, 32'h1);
      repeat (3) @(negedge clk);

      // SRL by 13 with an ignored start in cycle 3
      a = cyc;
      go("srl13", 2'b01, 5'd13, 32'h80000000, 32'h00040000, 7, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         check($sformatf("srl13_busy_c%0d", k), {31'h0, busy}, 32'h1);
         if (cyc == a + 3) begin
            start   = 1'b1;
            op      = 2'b00;
            shamt   = 5'd1;
            data_in = 32'hFFFFFFFF;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      repeat (3) @(negedge clk);

      // extra patterns
      go("sll31", 2'b00, 5'd31, 32'h00000001, 32'h80000000, 11, 1'b1);
      repeat (12) @(negedge clk);
      go("srl16", 2'b01, 5'd16, 32'hABCD1234, 32'h0000ABCD, 3, 1'b1);
      repeat (4) @(negedge clk);

      // SRA by 31, then back-to-back start in the done cycle
      go("sra31", 2'b10, 5'd31, 32'h80000000, 32'hFFFFFFFF, 11, 1'b1);
      repeat (10) @(negedge clk);
      go("sra4_b2b", 2'b10, 5'd4, 32'h7FFFFFF0, 32'h07FFFFFF, 5, 1'b1);
      repeat (6) @(negedge clk);

      // reset mid-shift
      go("srl20_abort", 2'b01, 5'd20, 32'hFFFFFFFF, 32'h0, 0, 1'b0);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("abort_busy",   {31'h0, busy}, 32'h0);
      check("abort_done",   {31'h0, done}, 32'h0);
      check("abort_result", result,        32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      go("sll1_after_rst", 2'b00, 5'd1, 32'h00000003, 32'h00000006, 2, 1'b1);
      repeat (3) @(negedge clk);

      // op 11
`ifdef SHIFT_ROTATE_EN
      go("op11", 2'b11, 5'd4, 32'h12345678, 32'h81234567, 5, 1'b1);
`else
      go("op11", 2'b11, 5'd4, 32'h12345678, 32'h01234567, 5, 1'b1);
`endif

      for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending done, required 0", sbq.size());
      end
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
